uart_rx_buffer: RTL and testbench
=================================

Name: uart_rx_buffer

Overview:
- Byte FIFO between the UART receiver and the register-write stage.
- Captures each received byte on `rx_valid`, holds it, and presents the oldest byte zero-extended to 32 bits as `input_data`, with `input_ready`.
- The register-write stage consumes the head entry by pulsing `pop`, driven from its `UART_write_enable`.
- Gives UART input reads a non-blocking source whenever data is buffered, and records bytes lost to overflow.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries (16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- rx_data  input  8  byte from UART receiver.
- rx_valid  input  1  one-cycle strobe: rx_data valid this cycle.
- pop  input  1  consume head entry (connect to UART_write_enable).
- input_data  output  32  {24'b0, head byte}; 0 when empty.
- input_ready  output  1  FIFO non-empty.
- count  output  DEPTH_LOG2+1  number of stored entries, 0..2**DEPTH_LOG2.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Storage:
  - Circular buffer `mem[0..2**DEPTH_LOG2-1]` of 8-bit entries.
  - Write pointer `wp` and read pointer `rp`, each DEPTH_LOG2 bits, wrapping modulo depth.
  - Occupancy counter `cnt`, DEPTH_LOG2+1 bits.
- Reset (reset==0 at a clock edge): `wp=0`, `rp=0`, `cnt=0`, `overflow=0`. `mem` contents are not cleared.
- Outputs after reset: `input_ready=0`, `input_data=0`, `count=0`, `overflow=0`.
- Reset takes priority over any `rx_valid`/`pop` in the same cycle.
- Outputs are decoded purely from registered state, with no combinational path from `rx_valid` or `pop`:
  - `input_ready = (cnt!=0)`.
  - `input_data = input_ready ? {24'b0, mem[rp]} : 32'b0`.
  - `count = cnt`.
- Push, defined as `rx_valid && (cnt<DEPTH || pop_eff)`:
  - `mem[wp] <= rx_data`, `wp <= wp+1`.
- Effective pop, `pop_eff = pop && cnt!=0`:
  - `rp <= rp+1`.
  - Pop while empty is ignored; no pointer or count change.
- Count update:
  - push only: `cnt+1`.
  - pop_eff only: `cnt-1`.
  - both or neither: unchanged.
- Full with simultaneous pop: the push is accepted (write to `mem[wp]`, where `wp==rp` slot is being freed); `cnt` stays at DEPTH.
- Full without pop: `rx_valid` byte is dropped, `overflow <= 1`, pointers and `cnt` unchanged.
- `overflow` is cleared only by reset.
- Empty with simultaneous `rx_valid` and `pop`: the pop is ignored and the push is accepted. The new byte appears on `input_data` in the next cycle.
- Latency:
  - A byte strobed in cycle N is visible on `input_data`/`input_ready` in cycle N+1 if the FIFO was empty.
  - A pop in cycle N exposes the next entry, or deasserts `input_ready`, in cycle N+1.
- Ordering is strict FIFO; pointer wrap from 2**DEPTH_LOG2-1 to 0 is seamless.
- The consumer may hold `pop` high for several cycles; one entry is removed per cycle while non-empty.

Test Plan:
- Reset with reset=0 for 2 cycles, then reset=1 -> `input_ready=0`, `input_data=0`, `count=0`, `overflow=0`.
- Push 0x41, then pop the cycle after ready -> `input_data=0x00000041` and `input_ready=1` one cycle after the strobe; `input_ready=0` and `count=0` the cycle after the pop.
- Push 16 bytes 0x00..0x0F, then a 17th byte 0xAA with no pop -> `count=16`, `overflow=1`. Pop 16 times yields 0x00..0x0F in order; 0xAA is never seen.
- Full FIFO with `rx_valid`=0x55 and `pop` in the same cycle -> `count` stays 16, `overflow` stays 0, head advances. After 15 more pops `input_data=0x55`.
- Wrap: 40 push/pop pairs with occupancy held at 1–3 -> data order is preserved across pointer wrap and `count` never exceeds 3.
- Empty FIFO with simultaneous `rx_valid`=0x7E and `pop` -> next cycle `count=1`, `input_data=0x0000007E`. Reset asserted mid-stream with `count=5` -> next cycle `count=0` and `input_ready=0`.

Source files
------------

// File: rtl/uart_rx_buffer_if.sv
// uart_rx_buffer_if
//   Bundles the byte-capture and head-consume handshake of the UART receive
//   FIFO into a single port.
//   master : producer/consumer side (drives rx_data, rx_valid, pop)
//   slave  : FIFO side (drives input_data, input_ready, count, overflow)
//   rx_data     [7:0]          byte from the UART receiver
//   rx_valid                   one-cycle strobe, rx_data valid this cycle
//   pop                        consume head entry (UART_write_enable)
//   input_data  [31:0]         head byte zero-extended, 0 when empty
//   input_ready                FIFO non-empty
//   count       [DEPTH_LOG2:0] number of stored entries
//   overflow                   sticky: a byte was dropped while full
interface uart_rx_buffer_if #(
    parameter int unsigned DEPTH_LOG2 = 4
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  pop;
    logic [31:0]           input_data;
    logic                  input_ready;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;

    modport master (
        output rx_data,
        output rx_valid,
        output pop,
        input  input_data,
        input  input_ready,
        input  count,
        input  overflow
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  pop,
        output input_data,
        output input_ready,
        output count,
        output overflow
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer
//   Byte FIFO between the UART receiver and the register-write stage.
//   Bytes strobed by rx_valid are stored in a circular buffer; the oldest
//   byte is presented zero-extended on input_data while input_ready is high,
//   and is consumed by pop. Bytes arriving while full (and not being popped
//   the same cycle) are dropped and latched in the sticky overflow flag.
//   All outputs decode from registered state only.
//   clk    : system clock, rising-edge
//   reset  : synchronous, active-low
//   bus    : uart_rx_buffer_if.slave (rx_data/rx_valid/pop in,
//            input_data/input_ready/count/overflow out)
module uart_rx_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic               clk,
    input  logic               reset,
    uart_rx_buffer_if.slave    bus
);

    localparam int unsigned           DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  overflow_q, overflow_d;

    logic                  not_empty;
    logic                  full;
    logic                  pop_eff;
    logic                  push;

    // Next-state logic
    always_comb begin
        not_empty  = (cnt_q != '0);
        full       = (cnt_q == CNT_FULL);
        pop_eff    = bus.pop && not_empty;
        // A full FIFO still accepts a byte when the head is freed this cycle;
        // the slot at wp equals rp in that case, and its old value is being
        // read out now, so overwriting it at the edge is safe.
        push       = bus.rx_valid && (!full || pop_eff);

        mem_d      = mem_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;

        if (push) begin
            mem_d[wp_q] = bus.rx_data;
            wp_d        = wp_q + PTR_ONE;
        end

        if (pop_eff) begin
            rp_d = rp_q + PTR_ONE;
        end

        case ({push, pop_eff})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        if (bus.rx_valid && !push) begin
            overflow_d = 1'b1;
        end
    end

    // Control state
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not cleared by reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= mem_d;
        end
    end

    // Outputs
    always_comb begin
        bus.input_ready = not_empty;
        bus.input_data  = not_empty ? {24'h0, mem_q[rp_q]} : '0;
        bus.count       = cnt_q;
        bus.overflow    = overflow_q;
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer
//   Drives directed and randomized traffic into uart_rx_buffer. A queue-based
//   reference model predicts the visible state each cycle and the byte
//   consumed by each accepted pop; a separate monitor compares on the
//   falling edge.
module tb_uart_rx_buffer;

    localparam int unsigned DL2   = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic        ready;
        logic [31:0] data;
        logic [4:0]  count;
        logic        ovf;
    } snap_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    uart_rx_buffer_if #(.DEPTH_LOG2(DL2)) bus ();

    uart_rx_buffer #(.DEPTH_LOG2(DL2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model and scoreboard queues
    logic [7:0]  model_q [$];
    logic        model_ovf   = 1'b0;
    bit          model_known = 1'b0;
    snap_t       exp_snap_q [$];
    logic [7:0]  exp_byte_q [$];

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic snap_t model_snap();
        snap_t s;
        s.ready = (model_q.size() != 0);
        s.data  = s.ready ? {24'h0, model_q[0]} : 32'h0;
        s.count = 5'(model_q.size());
        s.ovf   = model_ovf;
        return s;
    endfunction

    // One clock of stimulus. Pushes the expectation for the state visible in
    // this cycle, then advances the model across the coming edge.
    task automatic cycle(input logic rst, input logic v, input logic [7:0] d,
                         input logic p);
        bit pe;
        reset        = rst;
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.pop      = p;
        if (model_known) exp_snap_q.push_back(model_snap());
        if (!rst) begin
            model_q.delete();
            model_ovf   = 1'b0;
            model_known = 1'b1;
        end else if (model_known) begin
            pe = p && (model_q.size() > 0);
            if (pe) begin
                exp_byte_q.push_back(model_q[0]);
                void'(model_q.pop_front());
            end
            if (v) begin
                if (model_q.size() < DEPTH) model_q.push_back(d);
                else                        model_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor
    snap_t      mon_e, mon_a;
    logic [7:0] mon_b;

    always @(negedge clk) begin
        if (exp_snap_q.size() > 0) begin
            mon_e = exp_snap_q.pop_front();
            mon_a = {bus.input_ready, bus.input_data, bus.count, bus.overflow};
            n_vec++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL state t=%0t: got ready=%b data=%h count=%0d ovf=%b, expected ready=%b data=%h count=%0d ovf=%b",
                         $time, mon_a.ready, mon_a.data, mon_a.count, mon_a.ovf,
                         mon_e.ready, mon_e.data, mon_e.count, mon_e.ovf);
            end
        end
        if (reset === 1'b1 && bus.pop === 1'b1 && bus.input_ready === 1'b1) begin
            n_vec++;
            if (exp_byte_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_data t=%0t: got data=%h, expected no byte", $time, bus.input_data);
            end else begin
                mon_b = exp_byte_q.pop_front();
                if (bus.input_data !== {24'h0, mon_b}) begin
                    n_err++;
                    $display("FAIL pop_data t=%0t: got data=%h, expected %h", $time,
                             bus.input_data, {24'h0, mon_b});
                end
            end
        end
    end

    int unsigned pv_tab [6] = '{80, 20, 50, 95, 10, 60};
    int unsigned pp_tab [6] = '{20, 80, 50, 10, 95, 55};

    initial begin
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.pop      = 1'b0;

        // Reset for two cycles
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        idle(1);

        // Single byte, pop the cycle after it becomes ready
        cycle(1'b1, 1'b1, 8'h41, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        idle(2);

        // Fill, overflow with 0xAA, drain holding pop
        for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        idle(1);
        for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        idle(1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);   // pop while empty
        idle(1);

        // Full with simultaneous push of 0x55 and pop
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        for (int unsigned i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 8'(8'h30 + i), 1'b0);
        cycle(1'b1, 1'b1, 8'h55, 1'b1);
        for (int unsigned i = 0; i < DEPTH - 1; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        idle(1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        idle(1);

        // Wrap with occupancy held low
        cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
        cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
        for (int unsigned i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 8'($urandom), 1'b1);
            if (i % 7 == 3) cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
            if (i % 7 == 5) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        end
        for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        idle(1);

        // Empty with simultaneous push and pop, then reset mid-stream at count 5
        cycle(1'b1, 1'b1, 8'h7E, 1'b1);
        for (int unsigned i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
        idle(1);
        cycle(1'b0, 1'b1, 8'h99, 1'b1);
        idle(2);

        // Randomized phases
        for (int unsigned i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 99) < pv_tab[i / 100]) ? 1'b1 : 1'b0,
                  8'($urandom),
                  ($urandom_range(0, 99) < pp_tab[i / 100]) ? 1'b1 : 1'b0);
        end
        idle(2);
        @(negedge clk);
        #1;

        n_vec++;
        if (exp_snap_q.size() != 0 || exp_byte_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d state and %0d byte expectations left, expected 0 and 0",
                     exp_snap_q.size(), exp_byte_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
